// File: rtl/td4_run_ctrl.sv
// td4_run_ctrl: TD4 execution sequencer with run/stop/step, PC breakpoint, CPU clear and instruction counter.
// Define TD4_SELF_LOOP_HALT_EN to halt when the program settles into a "JMP self" loop.
module td4_run_ctrl #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_req,
  input  logic             stop_req,
  input  logic             step_req,
  input  logic             clear_req,
  input  logic [DIV_W-1:0] div_val,
  input  logic             bp_valid,
  input  logic [3:0]       bp_addr,
  input  logic [3:0]       pc,
  output logic             cpu_en,
  output logic             cpu_rst,
  output logic [2:0]       state,
  output logic             busy,
  output logic [CNT_W-1:0] insn_cnt
);
  typedef enum logic [2:0] {IDLE = 3'd0, RUN = 3'd1, STEP = 3'd2, BREAK = 3'd3, HALT = 3'd4} state_t;
  state_t state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic en_q, en_d, chk_q, skip_q, skip_d, crst_q, busy_q;
  logic bp_hit, halt_hit, wake;
`ifdef TD4_SELF_LOOP_HALT_EN
  logic [3:0] lat_q;
  logic from_step_q;
  assign halt_hit = chk_q && pc == lat_q && (state_q == RUN || from_step_q);
`else
  assign halt_hit = 1'b0;
`endif
  // chk_q marks the cycle after cpu_en, when the CPU's new pc is visible
  assign bp_hit = chk_q && state_q == RUN && bp_valid && pc == bp_addr && !skip_q;
  assign wake = state_q == IDLE || state_q == BREAK;
  always_comb begin
    state_d = clear_req ? IDLE : halt_hit ? HALT : bp_hit ? BREAK
            : state_q == RUN ? (stop_req ? IDLE : RUN)
            : wake ? (stop_req ? IDLE : step_req ? STEP : run_req ? RUN : state_q)
            : state_q == STEP ? IDLE : state_q;
    div_d = (state_d == RUN && div_q < div_val) ? div_q + 1'b1 : '0;
    en_d = state_d == STEP || (state_d == RUN && div_q >= div_val);
    skip_d = (state_d == RUN && state_q != RUN) ? state_q == BREAK
           : (chk_q && state_q == RUN) ? 1'b0 : skip_q;
    cnt_d = clear_req ? '0 : (en_q && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q <= '0;
      cnt_q <= '0;
      en_q <= 1'b0;
      chk_q <= 1'b0;
      skip_q <= 1'b0;
      crst_q <= 1'b1;
      busy_q <= 1'b0;
`ifdef TD4_SELF_LOOP_HALT_EN
      lat_q <= 4'h0;
      from_step_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
      en_q <= en_d;
      chk_q <= en_q && !clear_req;
      skip_q <= skip_d;
      crst_q <= clear_req;
      busy_q <= state_d == RUN || state_d == STEP;
`ifdef TD4_SELF_LOOP_HALT_EN
      lat_q <= en_q ? pc : lat_q;
      from_step_q <= state_q == STEP;
`endif
    end
  end
  assign cpu_en = en_q;
  assign cpu_rst = crst_q;
  assign state = state_q;
  assign busy = busy_q;
  assign insn_cnt = cnt_q;
endmodule

// File: tb/tb_td4_run_ctrl.sv
// tb_td4_run_ctrl: directed stimulus against a cycle-scheduled behavioural model of the sequencer.
module tb_td4_run_ctrl;
  localparam int IDLE = 0, RUN = 1, STEP = 2, BRK = 3, HALT = 4;
`ifdef TD4_SELF_LOOP_HALT_EN
  localparam bit HALT_ON = 1'b1;
`else
  localparam bit HALT_ON = 1'b0;
`endif
  logic clk = 0, rst = 1, run_req = 0, stop_req = 0, step_req = 0, clear_req = 0, bp_valid = 0, pc_hold = 0;
  logic [15:0] div_val = 0;
  logic [3:0] bp_addr = 0, pc = 0;
  logic cpu_en, cpu_rst, busy, cpu_en4, cpu_rst4, busy4;
  logic [2:0] state, state4;
  logic [15:0] insn_cnt;
  logic [3:0] insn_cnt4;
  int checks = 0, errors = 0, t = 0;
  int m_st = IDLE, m_cnt = 0, m_next = 0;
  bit m_en = 0, m_rst = 1, m_skip = 0, m_ck = 0, m_ck_step = 0, started = 0;
  logic [3:0] m_lat = 0;

  always #5 clk = ~clk;

  td4_run_ctrl dut (.clk(clk), .rst(rst), .run_req(run_req), .stop_req(stop_req), .step_req(step_req),
    .clear_req(clear_req), .div_val(div_val), .bp_valid(bp_valid), .bp_addr(bp_addr), .pc(pc),
    .cpu_en(cpu_en), .cpu_rst(cpu_rst), .state(state), .busy(busy), .insn_cnt(insn_cnt));
  td4_run_ctrl #(.DIV_W(16), .CNT_W(4)) dut4 (.clk(clk), .rst(rst), .run_req(run_req), .stop_req(stop_req),
    .step_req(step_req), .clear_req(clear_req), .div_val(div_val), .bp_valid(bp_valid), .bp_addr(bp_addr),
    .pc(pc), .cpu_en(cpu_en4), .cpu_rst(cpu_rst4), .state(state4), .busy(busy4), .insn_cnt(insn_cnt4));

  // stand-in CPU: pc counts up per instruction, or jumps to F and stays there when pc_hold is set
  always @(posedge clk) pc <= cpu_rst ? 4'h0 : cpu_en ? (pc_hold ? 4'hF : pc + 4'h1) : pc;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    bit pe, halt, bp;
    int ps;
    pe = m_en;
    ps = m_st;
    t++;
    started = 1;
    if (m_en) m_cnt++;
    m_en = 0;
    m_rst = 0;
    if (rst || clear_req) begin
      m_st = IDLE; m_rst = 1; m_cnt = 0; m_skip = 0; m_ck = 0; m_ck_step = 0;
    end else begin
      halt = HALT_ON && m_ck && pc == m_lat && (ps == RUN || m_ck_step);
      bp = m_ck && ps == RUN && bp_valid && pc == bp_addr && !m_skip;
      if (m_ck && ps == RUN) m_skip = 0;
      if (halt) m_st = HALT;
      else if (bp) m_st = BRK;
      else if (ps == RUN) m_st = stop_req ? IDLE : RUN;
      else if (ps == STEP) m_st = IDLE;
      else if (ps != HALT) begin
        if (stop_req) m_st = IDLE;
        else if (step_req) m_st = STEP;
        else if (run_req) begin
          m_st = RUN;
          m_skip = ps == BRK;
          m_next = t + int'(div_val);
        end
      end
      if (m_st == RUN && t == m_next) begin
        m_en = 1;
        m_next = t + int'(div_val) + 1;
      end
      m_en = m_en || m_st == STEP;
      m_ck = pe;
      m_ck_step = pe && ps == STEP;
      if (pe) m_lat = pc;
    end
  end

  always @(negedge clk) if (started) begin
    chk("state", int'(state), m_st);
    chk("cpu_en", int'(cpu_en), int'(m_en));
    chk("cpu_rst", int'(cpu_rst), int'(m_rst));
    chk("busy", int'(busy), int'(m_st == RUN || m_st == STEP));
    chk("insn_cnt", int'(insn_cnt), m_cnt > 65535 ? 65535 : m_cnt);
    chk("state4", int'(state4), m_st);
    chk("cpu_en4", int'(cpu_en4), int'(m_en));
    chk("cpu_rst4", int'(cpu_rst4), int'(m_rst));
    chk("busy4", int'(busy4), int'(m_st == RUN || m_st == STEP));
    chk("insn_cnt4", int'(insn_cnt4), m_cnt > 15 ? 15 : m_cnt);
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    cyc(3);
    chk("rst_state", int'(state), 0);
    chk("rst_cpu_rst", int'(cpu_rst), 1);
    chk("rst_cnt", int'(insn_cnt), 0);
    rst = 0;
    div_val = 3;
    cyc(2);
    run_req = 1; cyc(1); run_req = 0;
    cyc(2); chk("run_no_early_en", int'(cpu_en), 0);
    cyc(1); chk("run_first_en", int'(cpu_en), 1);
    cyc(3); chk("run_gap", int'(cpu_en), 0);
    cyc(1); chk("run_second_en", int'(cpu_en), 1);
    cyc(13); chk("run_cnt5", int'(insn_cnt), 5);
    stop_req = 1; run_req = 1; cyc(1); stop_req = 0; run_req = 0;
    chk("stoprun_idle", int'(state), 0);
    cyc(8); chk("stoprun_no_en", int'(insn_cnt), 5);
    stop_req = 1; cyc(1); stop_req = 0;
    chk("stop_in_idle", int'(state), 0);
    step_req = 1; cyc(1); step_req = 0;
    chk("step_en", int'(cpu_en), 1);
    chk("step_state", int'(state), 2);
    cyc(1);
    chk("step_idle", int'(state), 0);
    chk("step_cnt", int'(insn_cnt), 6);
    chk("step_single", int'(cpu_en), 0);
    clear_req = 1; step_req = 1; cyc(1); clear_req = 0; step_req = 0;
    chk("clr_rst", int'(cpu_rst), 1);
    chk("clr_cnt", int'(insn_cnt), 0);
    chk("clr_en", int'(cpu_en), 0);
    cyc(1);
    chk("clr_rst_end", int'(cpu_rst), 0);
    chk("clr_no_en", int'(cpu_en), 0);
    bp_valid = 1; bp_addr = 4'h3; div_val = 1;
    run_req = 1; cyc(1); run_req = 0;
    for (int i = 0; i < 40 && state != 3'd3; i++) cyc(1);
    chk("bp_state", int'(state), 3);
    chk("bp_pc", int'(pc), 3);
    chk("bp_cnt", int'(insn_cnt), 3);
    cyc(4);
    chk("bp_hold_state", int'(state), 3);
    chk("bp_hold_cnt", int'(insn_cnt), 3);
    run_req = 1; cyc(1); run_req = 0;
    for (int i = 0; i < 40 && pc != 4'h6; i++) cyc(1);
    chk("bp_resume_pc", int'(pc), 6);
    chk("bp_resume_state", int'(state), 1);
    stop_req = 1; cyc(1); stop_req = 0; bp_valid = 0;
    clear_req = 1; cyc(1); clear_req = 0;
    pc_hold = 1; div_val = 0;
    run_req = 1; cyc(1); run_req = 0;
    cyc(6);
    chk("halt_state", int'(state), HALT_ON ? 4 : 1);
    run_req = 1; cyc(1); run_req = 0; step_req = 1; cyc(1); step_req = 0; cyc(1);
    chk("halt_sticky", int'(state), HALT_ON ? 4 : 1);
    clear_req = 1; cyc(1); clear_req = 0;
    chk("halt_clear", int'(state), 0);
    pc_hold = 0;
    for (int i = 0; i < 20; i++) begin
      step_req = 1; cyc(1); step_req = 0; cyc(2);
    end
    chk("sat_cnt", int'(insn_cnt), 20);
    chk("sat_cnt4", int'(insn_cnt4), 15);
    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/td4_run_ctrl.md
Name: td4_run_ctrl

Overview:
Execution sequencer for the 4-bit TD4 CPU core. It generates the per-instruction enable that advances the CPU (PC, A/B registers, output port, carry flag) from the fast system clock, and provides run/stop/single-step control, a PC breakpoint, a CPU clear and an executed-instruction counter. It sits between the board-level control inputs (buttons/UART debug) and the CPU's clock-enable and reset inputs.

Parameters:
DIV_W, 16, width of the clock-divider reload value
CNT_W, 16, width of the executed-instruction counter

Ports:
clk        input   1       system clock
rst        input   1       reset, synchronous, active-high
run_req    input   1       one-cycle pulse: start or resume free-running execution
stop_req   input   1       one-cycle pulse: stop execution
step_req   input   1       one-cycle pulse: execute exactly one instruction
clear_req  input   1       one-cycle pulse: reset CPU and controller state
div_val    input   DIV_W   cycles between instructions minus 1 (0 = one instruction per clk)
bp_valid   input   1       breakpoint enable
bp_addr    input   4       breakpoint PC value
pc         input   4       CPU program counter; valid the cycle after cpu_en
cpu_en     output  1       one-cycle pulse: CPU executes one instruction at this edge
cpu_rst    output  1       synchronous reset to the CPU
state      output  3       0 IDLE, 1 RUN, 2 STEP, 3 BREAK, 4 HALT
busy       output  1       state is RUN or STEP
insn_cnt   output  CNT_W   instructions executed since reset or clear

Behaviour:
- Reset: state IDLE; cpu_en=0; cpu_rst=1 while rst is high; insn_cnt=0; div_cnt=0; busy=0. All outputs are registered.
- Request priority when several requests arrive in the same cycle: clear_req > stop_req > step_req > run_req.
- clear_req (any state): cpu_rst=1 for exactly the next cycle. In that cycle state=IDLE, insn_cnt=0, div_cnt=0, cpu_en=0.
- IDLE: run_req -> RUN. step_req -> STEP. stop_req is ignored.
- RUN: div_cnt increments every cycle. When div_cnt==div_val, cpu_en=1 on the next cycle and div_cnt returns to 0.
  - div_val is sampled at each compare, so a change takes effect at the following interval.
  - The first cpu_en follows run_req by div_val+1 cycles.
  - stop_req -> IDLE. No cpu_en is issued from the cycle after stop_req onward, and div_cnt clears.
- STEP: cpu_en=1 for the first cycle in STEP, then return to IDLE (or BREAK/HALT per the checks below). Total latency is step_req at n -> cpu_en at n+1 -> IDLE at n+2. The divider is not used.
- Breakpoint check: performed the cycle after each cpu_en in RUN only. If bp_valid and pc==bp_addr -> BREAK, and no further cpu_en is issued.
- BREAK: run_req resumes RUN with a skip-first rule: the first instruction after resume is never checked against the breakpoint. step_req -> STEP. stop_req -> IDLE.
- HALT: only clear_req leaves HALT. run_req, step_req and stop_req are ignored.
- insn_cnt: increments on every cpu_en and saturates at all-ones (no wrap).
- cpu_en is never asserted in IDLE, BREAK or HALT, or while cpu_rst=1.
- rst or clear_req mid-interval: the partially counted divider interval is discarded, with no late cpu_en.

Optional Feature:
TD4_SELF_LOOP_HALT_EN
- Defined: the controller latches pc on each cpu_en. If the pc in the cycle after cpu_en equals the latched value (the program's terminating "JMP self"), state -> HALT from RUN or STEP. This check takes precedence over the breakpoint check.
- Undefined: no pc latch is built, HALT is unreachable, and state never equals 4.

Test Plan:
- rst, then run_req with div_val=3 -> first cpu_en 4 cycles after run_req, then every 4 cycles; after 5 pulses insn_cnt=5.
- From IDLE, step_req -> exactly one cpu_en at n+1, state=IDLE at n+2, insn_cnt=1; stop_req in IDLE -> no change.
- bp_valid=1, bp_addr=4'h3, program increments pc -> BREAK immediately after the cpu_en that yields pc=3. run_req -> execution resumes past pc=3 without re-breaking.
- stop_req and run_req in the same cycle while RUN -> IDLE, no further cpu_en. clear_req together with step_req -> cpu_rst pulses for 1 cycle, insn_cnt=0, no cpu_en.
- With TD4_SELF_LOOP_HALT_EN, pc held at 4'hF after cpu_en -> state=4. run_req and step_req are ignored; clear_req -> IDLE. Without the macro, same stimulus -> state remains RUN.
- CNT_W=4: 20 steps -> insn_cnt saturates at 4'hF.
